// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_state_e;

    localparam int unsigned APB_WORD_BYTES  = 4;
    localparam int unsigned MAX_WAIT_STATES = 15;

endpackage

// File: rtl/apb_reg_bank.sv
// NUM_REGS x DATA_WIDTH register array: one write port, one combinational read port.
module apb_reg_bank #(
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[widx] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                mem_q[i] <= '0;
            end else begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer decoding a window of NUM_REGS word registers with fixed wait
// states; out-of-window or misaligned accesses complete with pslverr.
module apb_regfile_slave
    import apb_slave_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            NUM_REGS    = 16,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
    parameter int unsigned            WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int unsigned           IDX_W  = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] WINDOW = ADDR_WIDTH'(NUM_REGS * APB_WORD_BYTES);
    localparam logic [3:0]            WS     = 4'(WAIT_STATES);

    apb_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;

    logic                  setup;
    logic                  addr_err;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  bank_we;
    logic [DATA_WIDTH-1:0] bank_rdata;

    assign setup    = psel && !penable;
    assign offset   = paddr - BASE_ADDR;
    assign addr_err = (paddr[1:0] != 2'b00) || (paddr < BASE_ADDR) || (offset >= WINDOW);

    apb_reg_bank #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk   (hclk),
        .rst   (hreset),
        .we    (bank_we),
        .widx  (idx_q),
        .wdata (wdata_q),
        .ridx  (idx_d),
        .rdata (bank_rdata)
    );

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = (WS == 4'd0) ? READY : WAIT;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (!psel || penable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The read port is addressed by idx_d so a zero-wait read can sample the
    // bank on the same edge that captures the address.
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        bank_we   = 1'b0;
        prdata_d  = '0;

        if (state_q == IDLE && setup) begin
            cnt_d   = WS;
            idx_d   = paddr[2 +: IDX_W];
            write_d = pwrite;
            wdata_d = pwdata;
            err_d   = addr_err;
        end

        if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end

        if (state_q == READY && psel && penable && write_q && !err_q) begin
            bank_we = 1'b1;
        end

        pready_d  = (state_d == READY);
        pslverr_d = (state_d == READY) && err_d;

        if (state_d == READY) begin
            if (state_q == READY) begin
                prdata_d = prdata_q;
            end else if (!err_d && !write_d) begin
                prdata_d = bank_rdata;
            end
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: directed and random APB transfers on a 0-wait and
// a 3-wait instance, checked against an array model of the register window.
module tb_apb_regfile_slave;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        hclk;
    logic        hreset;
    logic        psel0, psel1;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1;
    logic        pslverr0, pslverr1;

    int unsigned vectors;
    int unsigned miscompares;
    logic [31:0] model [2][16];

    apb_regfile_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .NUM_REGS    (16),
        .BASE_ADDR   (BASE),
        .WAIT_STATES (0)
    ) u_ws0 (
        .hclk    (hclk),
        .hreset  (hreset),
        .psel    (psel0),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata0),
        .pready  (pready0),
        .pslverr (pslverr0)
    );

    apb_regfile_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .NUM_REGS    (16),
        .BASE_ADDR   (BASE),
        .WAIT_STATES (3)
    ) u_ws3 (
        .hclk    (hclk),
        .hreset  (hreset),
        .psel    (psel1),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata1),
        .pready  (pready1),
        .pslverr (pslverr1)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic o_rdy(input int inst);
        return (inst != 0) ? pready1 : pready0;
    endfunction

    function automatic logic o_err(input int inst);
        return (inst != 0) ? pslverr1 : pslverr0;
    endfunction

    function automatic logic [31:0] o_data(input int inst);
        return (inst != 0) ? prdata1 : prdata0;
    endfunction

    task automatic set_psel(input int inst, input logic v);
        if (inst != 0) psel1 = v;
        else           psel0 = v;
    endtask

    function automatic logic is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'd64);
    endfunction

    function automatic int reg_of(input logic [31:0] a);
        return int'((a - BASE) >> 2) & 15;
    endfunction

    // Called just after a rising edge; returns just after the edge following completion.
    task automatic xfer(input int inst, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] rd, output logic er);
        int   lat;
        logic got;
        set_psel(inst, 1'b1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        check("setup_pready", 32'(o_rdy(inst)), 32'd0);
        @(posedge hclk); #1;
        penable = 1'b1;
        lat = 1;
        got = 1'b0;
        rd  = '0;
        er  = 1'b0;
        while (!got && lat < 40) begin
            if (o_rdy(inst)) begin
                got = 1'b1;
                rd  = o_data(inst);
                er  = o_err(inst);
            end else begin
                check("wait_prdata", o_data(inst), 32'd0);
                check("wait_pslverr", 32'(o_err(inst)), 32'd0);
                @(posedge hclk); #1;
                lat++;
            end
        end
        check("pready_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), (inst != 0) ? 32'd4 : 32'd1);
        @(posedge hclk); #1;
        set_psel(inst, 1'b0);
        penable = 1'b0;
        check("pready_width", 32'(o_rdy(inst)), 32'd0);
        check("idle_prdata", o_data(inst), 32'd0);
    endtask

    task automatic do_op(input int inst, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
        logic [31:0] rd;
        logic        er;
        logic        exp_err;
        exp_err = is_err(addr);
        xfer(inst, wr, addr, data, rd, er);
        check("pslverr", 32'(er), 32'(exp_err));
        if (exp_err) begin
            check("err_prdata", rd, 32'd0);
        end else if (wr) begin
            model[inst][reg_of(addr)] = data;
        end else begin
            check("rdata", rd, model[inst][reg_of(addr)]);
        end
    endtask

    task automatic readback_all(input int inst);
        for (int i = 0; i < 16; i++) begin
            do_op(inst, 1'b0, BASE + 32'(4 * i), 32'd0);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                model[k][i] = '0;
            end
        end
    endtask

    initial begin
        int          inst;
        int          r;
        logic [31:0] addr;

        vectors     = 0;
        miscompares = 0;
        clear_model();
        hreset  = 1'b1;
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        repeat (3) @(posedge hclk);
        #1;
        hreset = 1'b0;

        for (int k = 0; k < 2; k++) begin
            check("rst_pready", 32'(o_rdy(k)), 32'd0);
            check("rst_pslverr", 32'(o_err(k)), 32'd0);
            check("rst_prdata", o_data(k), 32'd0);
        end

        // Zero-wait read of an untouched register, then write/readback.
        do_op(0, 1'b0, BASE + 32'h8, 32'd0);
        do_op(0, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF);
        do_op(0, 1'b0, BASE + 32'h4, 32'd0);
        readback_all(0);

        // Three-wait write/read.
        do_op(1, 1'b1, BASE + 32'h20, 32'hCAFE_F00D);
        do_op(1, 1'b0, BASE + 32'h20, 32'd0);

        // Out-of-window, misaligned and below-base accesses.
        for (int k = 0; k < 2; k++) begin
            do_op(k, 1'b1, BASE + 32'h40, 32'h1111_1111);
            do_op(k, 1'b1, BASE + 32'h6, 32'h2222_2222);
            do_op(k, 1'b1, BASE - 32'h4, 32'h3333_3333);
            do_op(k, 1'b0, BASE + 32'h3C, 32'd0);
            do_op(k, 1'b0, BASE + 32'h41, 32'd0);
            readback_all(k);
        end

        // Randomised mix of reads and writes.
        for (int n = 0; n < 80; n++) begin
            inst = int'($urandom_range(0, 1));
            r    = int'($urandom_range(0, 9));
            if (r < 7)       addr = BASE + 32'(4 * $urandom_range(0, 15));
            else if (r == 7) addr = BASE + 32'($urandom_range(0, 63));
            else if (r == 8) addr = BASE + 32'h40 + 32'(4 * $urandom_range(0, 15));
            else             addr = BASE - 32'(4 * $urandom_range(1, 8));
            do_op(inst, 1'($urandom_range(0, 1)), addr, $urandom);
        end
        readback_all(0);
        readback_all(1);

        // psel dropped during the wait phase aborts the write.
        psel1   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = BASE + 32'hC;
        pwdata  = 32'h1234_5678;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(posedge hclk); #1;
        check("abort_wait_pready", 32'(pready1), 32'd0);
        psel1   = 1'b0;
        penable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge hclk); #1;
            check("abort_pready", 32'(pready1), 32'd0);
            check("abort_pslverr", 32'(pslverr1), 32'd0);
        end
        do_op(1, 1'b0, BASE + 32'hC, 32'd0);
        do_op(1, 1'b1, BASE + 32'h10, 32'h0BAD_CAFE);
        do_op(1, 1'b0, BASE + 32'h10, 32'd0);

        // Reset in the middle of a wait-phase write clears everything.
        do_op(1, 1'b1, BASE + 32'h14, 32'hA5A5_A5A5);
        do_op(1, 1'b0, BASE + 32'h14, 32'd0);
        psel1   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = BASE + 32'h14;
        pwdata  = 32'h0F0F_0F0F;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(posedge hclk); #1;
        check("rstwait_pready", 32'(pready1), 32'd0);
        hreset  = 1'b1;
        psel1   = 1'b0;
        penable = 1'b0;
        @(posedge hclk); #1;
        hreset = 1'b0;
        clear_model();
        for (int k = 0; k < 2; k++) begin
            check("midrst_pready", 32'(o_rdy(k)), 32'd0);
            check("midrst_pslverr", 32'(o_err(k)), 32'd0);
            check("midrst_prdata", o_data(k), 32'd0);
        end
        do_op(1, 1'b0, BASE + 32'h14, 32'd0);
        readback_all(1);
        readback_all(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
